// File: rtl/rr_sched.sv
// rr_sched: W-way round-robin scheduler; each grant is held until i_done, then priority moves past the winner.
// Latency: request to registered grant in 1 cycle; one idle cycle per hand-over, zero with RR_SCHED_B2B_EN defined.
// Backpressure: the owner keeps the resource until i_done; losing requesters hold i_req and wait their turn.

module dec #(
    parameter int W  = 4,
    parameter int EW = 2
) (
    input  logic [EW-1:0] enc,
    input  logic          en,
    output logic [W-1:0]  onehot
);
    always_comb begin
        onehot = '0;
        for (int i = 0; i < W; i++) begin
            onehot[i] = en && (enc == EW'(i));
        end
    end
endmodule

module rr_sched #(
    parameter int W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         i_req,
    input  logic                 i_done,
    output logic                 o_gnt_vld,
    output logic [$clog2(W)-1:0] o_gnt_enc,
    output logic [W-1:0]         o_gnt
);
    localparam int EW = $clog2(W);
    localparam logic [EW-1:0] LAST = EW'(W - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state;
    logic [EW-1:0] ptr;
    logic [EW-1:0] rel_ptr;
    logic [EW-1:0] base;
    logic [EW-1:0] win_enc;
    logic          win_any;
    logic [EW:0]   idx;

    // Pointer wraps at W, not at 2^EW, so it never names a missing requester.
    assign rel_ptr = (o_gnt_enc == LAST) ? '0 : o_gnt_enc + EW'(1);

    // A release arbitrates against the already-advanced pointer.
    assign base = (state == GRANT) ? rel_ptr : ptr;

    always_comb begin
        win_any = 1'b0;
        win_enc = '0;
        idx     = '0;
        for (int i = 0; i < W; i++) begin
            idx = {1'b0, base} + (EW+1)'(i);
            if (idx >= (EW+1)'(W)) begin
                idx = idx - (EW+1)'(W);
            end
            if (!win_any && i_req[idx[EW-1:0]]) begin
                win_any = 1'b1;
                win_enc = idx[EW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            o_gnt_vld <= 1'b0;
            o_gnt_enc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        state     <= GRANT;
                        o_gnt_vld <= 1'b1;
                        o_gnt_enc <= win_enc;
                    end
                end
                GRANT: begin
                    if (i_done) begin
                        ptr <= rel_ptr;
`ifdef RR_SCHED_B2B_EN
                        if (win_any) begin
                            o_gnt_enc <= win_enc;
                        end else begin
                            state     <= IDLE;
                            o_gnt_vld <= 1'b0;
                        end
`else
                        state     <= IDLE;
                        o_gnt_vld <= 1'b0;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    o_gnt_vld <= 1'b0;
                end
            endcase
        end
    end

    dec #(
        .W  (W),
        .EW (EW)
    ) u_dec (
        .enc    (o_gnt_enc),
        .en     (o_gnt_vld),
        .onehot (o_gnt)
    );

endmodule

// File: doc/rr_sched.md
# rr_sched

Round-robin scheduler that shares a single downstream resource among `W` requesters. It holds each grant until the owner signals completion, then advances priority past the winner. It presents the winner as a registered encoded index and as a one-hot vector; the one-hot form is produced by the common `dec` decoder applied to the encoded index. It sits in front of any shared datapath port (table write port, output bus) that needs fair, mutually exclusive ownership.

## Interface
- `W`, default 4, number of requesters; legal range 2..64; need not be a power of two.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `i_req`  in  W  per-requester request; level-sensitive.
- `i_done`  in  1  current owner releases the resource this cycle; sampled only in GRANT.
- `o_gnt_vld`  out  1  a grant is active.
- `o_gnt_enc`  out  $clog2(W)  index of current owner; valid when `o_gnt_vld`.
- `o_gnt`  out  W  one-hot grant (`dec` of `o_gnt_enc`, gated by `o_gnt_vld`); all-zero when no grant.

## Operation
- State machine, 2 states:
  - IDLE: no owner. If `i_req != 0`, select a winner and go to GRANT. Otherwise stay in IDLE.
  - GRANT: owner fixed. If `i_done`, go to IDLE, or stay in GRANT with a new owner when `RR_SCHED_B2B_EN` is set (see Configuration).
- Priority pointer `ptr` (`$clog2(W)` bits):
  - Arbitration picks the first set bit of `i_req` at index `ptr`, `ptr+1`, … `W-1`, `0`, … `ptr-1`.
  - On release of owner `k`: `ptr <= (k == W-1) ? 0 : k+1`. There is no mod-2^n wrap, so the pointer never takes a value ≥ `W`.
- The grant is held for the whole GRANT state regardless of `i_req`. The owner dropping its request does not revoke the grant; only `i_done` releases it.
- `i_done` in IDLE is ignored.
- `i_done` and new requests in the same cycle: the release is processed first, and the new requests arbitrate against the updated `ptr`.
- Single requester: it is re-granted repeatedly. There is no starvation because the pointer always advances past the winner.
- Reset: state IDLE, `ptr = 0`, `o_gnt_vld = 0`, `o_gnt_enc = 0`, `o_gnt = 0`. Reset during GRANT drops the grant on the next edge with no release handshake. `rst` dominates `i_req` and `i_done`.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Grant latency: `i_req` sampled in cycle t (IDLE) gives `o_gnt_vld = 1` in cycle t+1.
- Release: `i_done = 1` in cycle t (GRANT). The `ptr` update is visible at t+1.
- Without `RR_SCHED_B2B_EN`:
  - `o_gnt_vld = 0` at t+1.
  - The next grant appears at t+2 at the earliest, arbitrated on `i_req` at t+1.
  - This gives one bubble cycle per hand-over.
- With `RR_SCHED_B2B_EN`:
  - The next grant appears at t+1, arbitrated on `i_req` at t, with zero bubble.
  - If `i_req` at t is all-zero, `o_gnt_vld = 0` at t+1.
- Minimum grant length is 1 cycle: `i_done` in the first GRANT cycle is honoured.

## Configuration
- `RR_SCHED_B2B_EN` is the single compile-time macro. It selects back-to-back hand-over:
  - Defined: on `i_done`, re-arbitrate in the same cycle and transition GRANT→GRANT with the new owner.
  - Undefined: GRANT→IDLE always, which inserts exactly one idle cycle between owners.
- No other behaviour changes: reset values, arbitration order, pointer update and grant latency from IDLE are identical in both builds.

## Test plan
- Reset and single request, W=4, macro undefined: hold `rst` 2 cycles, then `i_req=4'b0100` → `o_gnt_vld=1`, `o_gnt_enc=2`, `o_gnt=4'b0100` exactly one cycle later; `i_done` pulse → `o_gnt=0` next cycle, regrant of index 2 one cycle after that.
- Fairness, W=4, `i_req=4'b1111` held, `i_done` every cycle a grant is active → owners sequence 0,1,2,3,0; undefined build shows a bubble between each, B2B build shows none.
- Non-power-of-two wrap, W=3: `ptr` at 2, `i_req=3'b101`, grant and release index 2 → `ptr=0`, next owner 0, and `o_gnt_enc` never equals 3.
- Grant hold: owner 1 granted, then `i_req=0` for 10 cycles with `i_done=0` → `o_gnt=4'b0010` stays asserted for all 10 cycles; `i_done` then releases it.
- Simultaneous release and request, B2B build: owner 3 releases while `i_req=4'b1001` → next cycle `o_gnt_enc=0` (pointer wrapped), no idle cycle.
- Reset mid-grant: owner 2 active, assert `rst` one cycle → next cycle all outputs are 0 and `ptr=0`; `i_req=4'b0101` afterwards → owner 0.
